// File: rtl/rr_arb_mux_4_1_pkg.sv
// Shared types and the round-robin pick function for the 4:1 arbiter mux.
package rr_arb_mux_4_1_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef struct packed {
    logic found;
    sel_t sel;
  } pick_t;

  // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set request wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input sel_t ptr);
    pick_t r;
    sel_t  idx;
    r = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + sel_t'(k);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.sel   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_4_1_if.sv
// Requester-side and output-side handshake bundle for rr_arb_mux_4_1.
interface rr_arb_mux_4_1_if
  import rr_arb_mux_4_1_pkg::*;
#(
  parameter int W = 4
);

  logic [N_REQ-1:0] in_valid;
  logic [W-1:0]     in_data0;
  logic [W-1:0]     in_data1;
  logic [W-1:0]     in_data2;
  logic [W-1:0]     in_data3;
  logic [N_REQ-1:0] in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  sel_t             out_sel;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arb_mux_4_1_rr_pick_4.sv
// Combinational round-robin winner selection over four requests.
module rr_pick_4
  import rr_arb_mux_4_1_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             gnt_valid,
  output sel_t             gnt_sel
);

  pick_t pick;

  assign pick      = rr_pick(req, ptr);
  assign gnt_valid = pick.found;
  assign gnt_sel   = pick.sel;

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Registered 4-input round-robin stream arbiter with W-bit 4:1 data select
// and a one-entry output register.
module rr_arb_mux_4_1
  import rr_arb_mux_4_1_pkg::*;
#(
  parameter int W = 4
) (
  input logic              clk,
  input logic              rst_n,
  rr_arb_mux_4_1_if.slave  bus
);

  logic                     out_valid_q;
  logic [W-1:0]             out_data_q;
  sel_t                     out_sel_q;
  sel_t                     ptr_q;

  logic                     load;
  logic                     gnt_valid;
  sel_t                     gnt_sel;
  logic                     take;
  logic [N_REQ-1:0][W-1:0]  data_arr;
  logic [W-1:0]             data_sel;

  // Output slot is free when empty or draining this edge.
  assign load = !out_valid_q || bus.out_ready;

  rr_pick_4 u_pick (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  assign take        = rst_n && load && gnt_valid;
  assign bus.in_ready = take ? (4'b0001 << gnt_sel) : 4'b0000;

  // Only the selected entry is read, so X on losers never propagates.
  assign data_arr = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
  assign data_sel = data_arr[gnt_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= sel_t'(N_REQ - 1);
    end else if (load) begin
      if (gnt_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_sel;
        out_sel_q   <= gnt_sel;
        ptr_q       <= gnt_sel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
